seq_alu_n: RTL and testbench
============================

Name: seq_alu_n

Overview:
- Parametrised, registered, handshaked ALU. It is the next generation of the team's 16-bit combinational ALU, generalised to WIDTH bits.
- Replaces the single-cycle array multiply with an iterative radix-2 Booth multiplier (one bit per cycle). Adds correct SUB flags and carry-out for shifts and rotates.
- Sits between the register-file read stage and writeback. Uses valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 4, power of 2).
- SHW, log2(WIDTH), number of valB bits used as the shift or rotate amount.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode are valid
- in_ready  output  1  block can accept an operation
- valA  input  WIDTH  operand A; the data being shifted or rotated
- valB  input  WIDTH  operand B; shift amount in valB[SHW-1:0]
- aluop  input  4  opcode: ADD 0001, SUB 0010, SHL 0101, SHAR 0110, SHLR 0111, RL 1000, RR 1001, AND 1011, OR 1100, XOR 1101, NOT 1110 (~valB), MUL 1111
- out_valid  output  1  result and cc are valid
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  registered result
- cc  output  4  registered {N,Z,C,V}
- illegal  output  1  qualified by out_valid; opcode was unlisted

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, result=0, cc=0000, illegal=0.
  - Multiplier registers are cleared.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, operands and opcode are captured. MUL goes to MUL state; every other opcode computes and goes to DONE.
  - MUL: runs a counter from 0 to WIDTH-1 with one Booth step per cycle. When the counter reaches WIDTH-1, the block writes result/cc and goes to DONE.
  - DONE: out_valid=1, in_ready=0. When out_ready=1, goes to IDLE. There is no same-cycle accept of a new operation.
- Latency, with the accept edge counted as edge 0:
  - Non-MUL: out_valid rises after edge 1.
  - MUL: out_valid rises after edge WIDTH+1.
- Outputs are stable while out_valid=1 and out_ready=0. Inputs are ignored outside IDLE.
- Arithmetic:
  - ADD: A+B.
  - SUB: A+~B+1.
  - C is the carry out of bit WIDTH-1. For SUB, C=1 means no borrow.
  - V is two's-complement overflow of the operation actually performed, using the inverted B for SUB.
- Shifts and rotates:
  - Amount is n = valB[SHW-1:0]. Upper bits of valB are ignored.
  - When n=0: result=valA, C=0.
  - Otherwise C is the last bit shifted or rotated out.
  - SHAR fills with valA[WIDTH-1].
  - For SHL, V=1 if any bit shifted out, or the new sign bit, differs from the original sign bit; otherwise V=0.
  - V=0 for all other shifts and rotates.
- MUL:
  - Signed × signed. result is the low WIDTH bits of the 2·WIDTH product.
  - C=V=1 if the full product is not representable in signed WIDTH bits; else C=V=0.
- Logic ops (AND/OR/XOR/NOT): C=V=0.
- N=result[WIDTH-1] and Z=(result==0) for all opcodes.
- Illegal opcodes (0000, 0011, 0100, 1010): result=0, cc=0100, illegal=1. Latency is the same as non-MUL.
- Reset asserted mid-MUL or in DONE: the operation is abandoned and no result is produced. After reset_n deasserts, in_ready=1 in the first cycle.

Test Plan:
- ADD (WIDTH=16), valA=0x7FFF, valB=0x0001 -> result=0x8000, cc=1001; out_valid one cycle after accept.
- SUB, 0x0005 - 0x0005 -> result=0x0000, cc=0110. SUB, 0x0000 - 0x0001 -> result=0xFFFF, cc=1000.
- MUL, 0xFFFD × 0x0004 -> result=0xFFF4, cc=1000, out_valid exactly 17 cycles after accept. MUL, 0x0100 × 0x0100 -> result=0x0000, cc=0111.
- Shifts and rotates:
  - RR, 0x8001 by 1 -> result=0xC000, cc=1010.
  - SHAR, 0x8000 by 15 -> result=0xFFFF, cc=1000.
  - SHL, 0x4000 by 1 -> result=0x8000, cc=1001.
  - valB=0x0013 shifts by 3, not 19.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> result/cc stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next cycle.
- Pulse reset_n low at cycle 8 of a MUL -> out_valid never rises for that operation, outputs are zero, and an ADD issued after reset completes normally. Opcode 0011 -> illegal=1, cc=0100.

Source files
------------

// File: rtl/seq_alu_n.sv
// rtl/seq_alu_n.sv - registered, handshaked WIDTH-bit ALU with iterative radix-2 Booth multiplier
module seq_alu_n #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [3:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [WIDTH:0]     acc_q, acc_sum, a_ext;
  logic [WIDTH-1:0]   mplr_q;
  logic               qm1_q;
  logic [SHW-1:0]     cnt_q;

  logic [WIDTH-1:0]   res_d;
  logic               c_d, v_d, ill_d;

  logic [SHW-1:0]     sh_n;
  logic [SHW:0]       inv_n;
  logic [WIDTH:0]     add_sum, sub_sum, shl_ext, shr_ext, sar_ext;
  logic [WIDTH-1:0]   b_inv, shl_back, rl_res, rr_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic               mul_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (aluop == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_MUL:  if (cnt_q == SHW'(WIDTH-1)) state_d = S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator carries one guard bit so subtracting the most negative multiplicand cannot wrap.
  assign a_ext = {a_q[WIDTH-1], a_q};

  always_comb begin
    acc_sum = acc_q;
    case ({mplr_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + a_ext;
      2'b10:   acc_sum = acc_q - a_ext;
      default: acc_sum = acc_q;
    endcase
  end

  assign prod     = {acc_q[WIDTH-1:0], mplr_q};
  assign prod_top = prod[2*WIDTH-1:WIDTH-1];
  assign mul_ovf  = !((&prod_top) || !(|prod_top));

  assign sh_n     = b_q[SHW-1:0];
  assign inv_n    = (SHW+1)'(WIDTH) - {1'b0, sh_n};
  assign b_inv    = ~b_q;
  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_sum  = {1'b0, a_q} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};
  // The extra bit beyond the data catches the last bit shifted out (zero when n=0).
  assign shl_ext  = {1'b0, a_q} << sh_n;
  assign shr_ext  = {a_q, 1'b0} >> sh_n;
  assign sar_ext  = $signed({a_q, 1'b0}) >>> sh_n;
  assign shl_back = $signed(shl_ext[WIDTH-1:0]) >>> sh_n;
  assign rl_res   = (a_q << sh_n) | (a_q >> inv_n);
  assign rr_res   = (a_q >> sh_n) | (a_q << inv_n);

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    ill_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = add_sum[WIDTH-1:0];
        c_d   = add_sum[WIDTH];
        v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = sub_sum[WIDTH-1:0];
        c_d   = sub_sum[WIDTH];
        v_d   = (a_q[WIDTH-1] == b_inv[WIDTH-1]) && (sub_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SHL: begin
        res_d = shl_ext[WIDTH-1:0];
        c_d   = shl_ext[WIDTH];
        v_d   = (shl_back != a_q);
      end
      OP_SHAR: begin
        res_d = sar_ext[WIDTH:1];
        c_d   = sar_ext[0];
      end
      OP_SHLR: begin
        res_d = shr_ext[WIDTH:1];
        c_d   = shr_ext[0];
      end
      OP_RL: begin
        res_d = rl_res;
        c_d   = (sh_n != '0) && rl_res[0];
      end
      OP_RR: begin
        res_d = rr_res;
        c_d   = (sh_n != '0) && rr_res[WIDTH-1];
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_NOT: res_d = b_inv;
      OP_MUL: begin
        res_d = prod[WIDTH-1:0];
        c_d   = mul_ovf;
        v_d   = mul_ovf;
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      cc      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q    <= valA;
          b_q    <= valB;
          op_q   <= aluop;
          acc_q  <= '0;
          mplr_q <= valB;
          qm1_q  <= 1'b0;
          cnt_q  <= '0;
        end
        S_MUL: begin
          acc_q  <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
          mplr_q <= {acc_sum[0], mplr_q[WIDTH-1:1]};
          qm1_q  <= mplr_q[0];
          cnt_q  <= cnt_q + SHW'(1);
        end
        S_EXEC: begin
          result  <= res_d;
          cc      <= {res_d[WIDTH-1], (res_d == '0), c_d, v_d};
          illegal <= ill_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_n.sv
// tb/tb_seq_alu_n.sv - randomized self-checking bench for seq_alu_n against a behavioural model
module tb_seq_alu_n;

  localparam int W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  logic         clk, reset_n, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [W-1:0] valA, valB, result;
  logic [3:0]   aluop, cc;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu_n #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .valA(valA), .valB(valB), .aluop(aluop), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cc(cc), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: shifts/rotates done one bit at a time, arithmetic in wide signed integers.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output logic [3:0] ccv, output logic ill);
    int sa, sb, s, n, t;
    longint p;
    logic [15:0] x, nb;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = int'(b[3:0]);
    x = a; c = 1'b0; v = 1'b0; ill = 1'b0; res = '0;
    case (op)
      OP_ADD: begin
        s = int'(a) + int'(b); res = s[15:0]; c = s[16];
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      OP_SUB: begin
        nb = ~b; s = int'(a) + int'(nb) + 1; res = s[15:0]; c = s[16];
        t = sa + int'($signed(nb)) + 1;
        v = (t > 32767) || (t < -32768);
      end
      OP_SHL: begin
        for (int i = 0; i < n; i++) begin c = x[15]; x = x << 1; end
        res = x; t = sa * (1 << n);
        v = (t > 32767) || (t < -32768);
      end
      OP_SHAR: begin
        for (int i = 0; i < n; i++) begin c = x[0]; x = {x[15], x[15:1]}; end
        res = x;
      end
      OP_SHLR: begin
        for (int i = 0; i < n; i++) begin c = x[0]; x = x >> 1; end
        res = x;
      end
      OP_RL: begin
        for (int i = 0; i < n; i++) begin c = x[15]; x = {x[14:0], x[15]}; end
        res = x;
      end
      OP_RR: begin
        for (int i = 0; i < n; i++) begin c = x[0]; x = {x[0], x[15:1]}; end
        res = x;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~b;
      OP_MUL: begin
        p = longint'(sa) * longint'(sb); res = p[15:0];
        v = (p > 32767) || (p < -32768); c = v;
      end
      default: ill = 1'b1;
    endcase
    ccv = {res[15], (res == 16'h0), c, v};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic [3:0] exp_cc, input logic exp_ill,
                        input int hold, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, ":in_ready"}, 32'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid = 1'b1; aluop = op; valA = a; valB = b;
    @(posedge clk); #1;
    in_valid = 1'b0; valA = 16'($urandom()); valB = 16'($urandom());
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":latency"}, 32'(cyc), (op == OP_MUL) ? 32'd17 : 32'd1);
    check({tag, ":result"}, 32'(result), 32'(exp_res));
    check({tag, ":cc"}, 32'(cc), 32'(exp_cc));
    check({tag, ":illegal"}, 32'(illegal), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; aluop = 4'($urandom()); valA = 16'($urandom()); valB = 16'($urandom());
      @(posedge clk); #1;
      check({tag, ":hold_result"}, 32'(result), 32'(exp_res));
      check({tag, ":hold_cc"}, 32'(cc), 32'(exp_cc));
      check({tag, ":hold_in_ready"}, 32'(in_ready), 0);
      check({tag, ":hold_out_valid"}, 32'(out_valid), 1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ":release_out_valid"}, 32'(out_valid), 0);
    check({tag, ":release_in_ready"}, 32'(in_ready), 1);
  endtask

  task automatic run_rand(input string tag);
    logic [3:0]  op, ecc;
    logic [15:0] a, b, eres;
    logic        eill;
    int          hold;
    op = 4'($urandom_range(0, 15));
    a = pick();
    b = pick();
    hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    model(op, a, b, eres, ecc, eill);
    run_op(op, a, b, eres, ecc, eill, hold, tag);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluop = '0; valA = '0; valB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:in_ready", 32'(in_ready), 1);
    check("reset:out_valid", 32'(out_valid), 0);
    check("reset:result", 32'(result), 0);
    check("reset:cc", 32'(cc), 0);
    check("reset:illegal", 32'(illegal), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0, 0, "add_ovf");
    run_op(OP_SUB,  16'h0005, 16'h0005, 16'h0000, 4'b0110, 1'b0, 0, "sub_zero");
    run_op(OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b1000, 1'b0, 0, "sub_borrow");
    run_op(OP_MUL,  16'hFFFD, 16'h0004, 16'hFFF4, 4'b1000, 1'b0, 0, "mul_neg");
    run_op(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b0111, 1'b0, 0, "mul_ovf");
    run_op(OP_MUL,  16'h8000, 16'h8000, 16'h0000, 4'b0111, 1'b0, 0, "mul_minmin");
    run_op(OP_RR,   16'h8001, 16'h0001, 16'hC000, 4'b1010, 1'b0, 0, "rr1");
    run_op(OP_SHAR, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000, 1'b0, 0, "shar15");
    run_op(OP_SHL,  16'h4000, 16'h0001, 16'h8000, 4'b1001, 1'b0, 0, "shl_sign");
    run_op(OP_SHL,  16'h0001, 16'h0013, 16'h0008, 4'b0000, 1'b0, 0, "shl_amt_mask");
    run_op(OP_SHLR, 16'h8005, 16'h0013, 16'h1000, 4'b0010, 1'b0, 0, "shlr_amt_mask");
    run_op(OP_RL,   16'h1234, 16'h0010, 16'h1234, 4'b0000, 1'b0, 0, "rl_zero_amt");
    run_op(OP_NOT,  16'h1234, 16'h00FF, 16'hFF00, 4'b1000, 1'b0, 0, "not_b");
    run_op(4'b0011, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b1, 0, "illegal_0011");
    run_op(OP_ADD,  16'h1234, 16'h1111, 16'h2345, 4'b0000, 1'b0, 5, "backpressure");

    // Abandon a multiply with an asynchronous reset partway through.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; aluop = OP_MUL; valA = 16'h0123; valB = 16'h0456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midmul:out_valid", 32'(out_valid), 0);
    check("midmul:result", 32'(result), 0);
    check("midmul:cc", 32'(cc), 0);
    check("midmul:illegal", 32'(illegal), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midmul:in_ready_after", 32'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midmul:no_out_valid", 32'(seen), 0);
    run_op(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1'b0, 0, "add_after_reset");

    for (int k = 0; k < 150; k++) run_rand("rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
